// File: rtl/pll_pkg.sv
// Shared state encoding, trim reset value and default wait times for the PLL sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_BIAS      = 3'd1,
        ST_CP        = 3'd2,
        ST_LOCKING   = 3'd3,
        ST_READY     = 3'd4,
        ST_STOP_VCO  = 3'd5,
        ST_STOP_CP   = 3'd6,
        ST_STOP_BIAS = 3'd7
    } pll_state_t;

    localparam int          CNT_W_DEF     = 16;
    localparam int          BIAS_WAIT_DEF = 16;
    localparam int          CP_WAIT_DEF   = 8;
    localparam int          LOCK_WAIT_DEF = 512;
    localparam logic [3:0]  TRIM_RST_DEF  = 4'b0100;

endpackage

// File: rtl/pll_wait_counter.sv
// Saturating wait counter with clear; done flags the last cycle of an N-cycle wait.
// Latency: clear takes effect on the next edge; done is combinational from count.
// Backpressure: none.
module pll_wait_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // count==limit-1 is the Nth cycle spent in the state
    assign done = (count == (limit - 1'b1));

endmodule

// File: rtl/pll_sequencer.sv
// PLL power-up/lock/shutdown sequencer driving bias, charge pump, VCO, trim and clock select.
// Latency: all outputs registered; clk_sel lags pll_ready/bypass by one cycle.
// Backpressure: none; enable is a level request, trim_we a one-cycle strobe.
module pll_sequencer
    import pll_pkg::*;
#(
    parameter int         CNT_W     = CNT_W_DEF,
    parameter int         BIAS_WAIT = BIAS_WAIT_DEF,
    parameter int         CP_WAIT   = CP_WAIT_DEF,
    parameter int         LOCK_WAIT = LOCK_WAIT_DEF,
    parameter logic [3:0] TRIM_RST  = TRIM_RST_DEF
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       enable,
    input  logic       bypass,
    input  logic       trim_we,
    input  logic [3:0] trim_wdata,
    output logic       bias_en,
    output logic       EN_CP,
    output logic       EN_VCO,
    output logic [3:0] B,
    output logic       pll_ready,
    output logic       clk_sel,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] BIAS_LIM = CNT_W'(BIAS_WAIT);
    localparam logic [CNT_W-1:0] CP_LIM   = CNT_W'(CP_WAIT);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_WAIT);

    pll_state_t       state_q;
    pll_state_t       state_nxt;
    logic             restart;
    logic             cnt_clr;
    logic             wait_done;
    logic [CNT_W-1:0] wait_lim;
    logic             bias_nxt;
    logic             cp_nxt;
    logic             vco_nxt;
    logic             ready_nxt;
    logic             sel_nxt;

    pll_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk   (CLK),
        .rst   (RESET),
        .clr   (cnt_clr),
        .en    (1'b1),
        .limit (wait_lim),
        .done  (wait_done)
    );

    always_comb begin
        wait_lim = CNT_W'(1);
        case (state_q)
            ST_BIAS:    wait_lim = BIAS_LIM;
            ST_CP:      wait_lim = CP_LIM;
            ST_LOCKING: wait_lim = LOCK_LIM;
            default:    wait_lim = CNT_W'(1);
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        restart   = 1'b0;
        case (state_q)
            ST_OFF:       if (enable) state_nxt = ST_BIAS;
            ST_BIAS: begin
                if (!enable)        state_nxt = ST_STOP_VCO;
                else if (wait_done) state_nxt = ST_CP;
            end
            ST_CP: begin
                if (!enable)        state_nxt = ST_STOP_VCO;
                else if (wait_done) state_nxt = ST_LOCKING;
            end
            ST_LOCKING: begin
                if (!enable)        state_nxt = ST_STOP_VCO;
                else if (trim_we)   restart   = 1'b1;
                else if (wait_done) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (!enable)        state_nxt = ST_STOP_VCO;
                else if (trim_we)   state_nxt = ST_LOCKING;
            end
            ST_STOP_VCO:  state_nxt = ST_STOP_CP;
            ST_STOP_CP:   state_nxt = ST_STOP_BIAS;
            ST_STOP_BIAS: state_nxt = ST_OFF;
            default:      state_nxt = ST_OFF;
        endcase
        cnt_clr = restart | (state_nxt != state_q);

        // Enables rise on entry to their stage and hold until their own STOP step is left
        bias_nxt  = (state_nxt == ST_BIAS) | (bias_en & (state_nxt != ST_OFF));
        cp_nxt    = (state_nxt == ST_CP) |
                    (EN_CP & (state_nxt inside {ST_CP, ST_LOCKING, ST_READY, ST_STOP_VCO, ST_STOP_CP}));
        vco_nxt   = (state_nxt == ST_LOCKING) |
                    (EN_VCO & (state_nxt inside {ST_LOCKING, ST_READY, ST_STOP_VCO}));
        ready_nxt = (state_nxt == ST_READY);
        // Rising edge follows pll_ready by a cycle; leaving READY drops it at once
        sel_nxt   = pll_ready & ~bypass & ready_nxt;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_OFF;
            bias_en   <= 1'b0;
            EN_CP     <= 1'b0;
            EN_VCO    <= 1'b0;
            pll_ready <= 1'b0;
            clk_sel   <= 1'b0;
            B         <= TRIM_RST;
        end else begin
            state_q   <= state_nxt;
            bias_en   <= bias_nxt;
            EN_CP     <= cp_nxt;
            EN_VCO    <= vco_nxt;
            pll_ready <= ready_nxt;
            clk_sel   <= sel_nxt;
            if (trim_we) B <= trim_wdata;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Randomized and directed bench for pll_sequencer against a timeline-based reference model.
module tb_pll_sequencer;
    import pll_pkg::*;

    localparam int BW = BIAS_WAIT_DEF;
    localparam int CW = CP_WAIT_DEF;
    localparam int LW = LOCK_WAIT_DEF;
    localparam logic [12:0] RST_VEC = {3'b000, 4'b0100, 2'b00, 3'd0};

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       enable = 1'b0;
    logic       bypass = 1'b0;
    logic       trim_we = 1'b0;
    logic [3:0] trim_wdata = 4'h0;
    logic       bias_en, EN_CP, EN_VCO, pll_ready, clk_sel;
    logic [3:0] B;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model: on/off plus elapsed time since bias rose and since the VCO (re)started locking
    bit         m_on, m_bias, m_cp, m_vco, m_ready, m_sel;
    int         m_sd, m_t, m_lock;
    logic [3:0] m_B;

    pll_sequencer dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .bypass(bypass),
        .trim_we(trim_we), .trim_wdata(trim_wdata),
        .bias_en(bias_en), .EN_CP(EN_CP), .EN_VCO(EN_VCO), .B(B),
        .pll_ready(pll_ready), .clk_sel(clk_sel), .state(state)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] m_state();
        if (m_sd == 3) return 3'd5;
        if (m_sd == 2) return 3'd6;
        if (m_sd == 1) return 3'd7;
        if (!m_on)     return 3'd0;
        if (m_ready)   return 3'd4;
        if (m_vco)     return 3'd3;
        if (m_cp)      return 3'd2;
        return 3'd1;
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bias_en, EN_CP, EN_VCO, B, pll_ready, clk_sel, state};
    endfunction

    function automatic logic [12:0] model_vec();
        return {m_bias, m_cp, m_vco, m_B, m_ready, m_sel, m_state()};
    endfunction

    task automatic model_reset();
        m_on = 0; m_bias = 0; m_cp = 0; m_vco = 0; m_ready = 0; m_sel = 0;
        m_sd = 0; m_t = 0; m_lock = 0; m_B = TRIM_RST_DEF;
    endtask

    task automatic model_step();
        bit prev_rdy;
        prev_rdy = m_ready;
        if (m_sd > 0) begin
            if (m_sd == 3) m_vco = 0;
            else if (m_sd == 2) m_cp = 0;
            else begin m_bias = 0; m_on = 0; end
            m_sd--;
        end else if (m_on) begin
            if (!enable) begin
                m_ready = 0;
                m_sd = 3;
            end else if (trim_we && m_vco) begin
                m_ready = 0;
                m_lock = 0;
            end else begin
                m_t++;
                if (!m_cp && m_t == BW) m_cp = 1;
                if (!m_vco && m_t == BW + CW) begin
                    m_vco = 1;
                    m_lock = 0;
                end else if (m_vco && !m_ready) begin
                    m_lock++;
                    if (m_lock == LW) m_ready = 1;
                end
            end
        end else if (enable) begin
            m_on = 1; m_bias = 1; m_t = 0;
        end
        if (trim_we) m_B = trim_wdata;
        m_sel = prev_rdy & ~bypass & m_ready;
    endtask

    task automatic tick();
        @(posedge CLK);
        if (RESET) model_reset();
        else model_step();
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        enable = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dut_vec() !== RST_VEC) begin
                errors++;
                $display("FAIL reset_values got %h exp %h", dut_vec(), RST_VEC);
            end
        end
        RESET = 1'b0;
    endtask

    task automatic test_powerup();
        int t_b, t_c, t_v, t_r, t_s;
        t_b = -1; t_c = -1; t_v = -1; t_r = -1; t_s = -1;
        enable = 1'b1;
        for (int n = 1; n < 700; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL powerup_cycle %0d got %h exp %h", n, dut_vec(), model_vec());
            end
            if (t_b < 0 && bias_en)   t_b = n;
            if (t_c < 0 && EN_CP)     t_c = n;
            if (t_v < 0 && EN_VCO)    t_v = n;
            if (t_r < 0 && pll_ready) t_r = n;
            if (t_s < 0 && clk_sel) begin t_s = n; break; end
        end
        checks++; if (t_b != 1) begin errors++; $display("FAIL bias_rise got %0d exp %0d", t_b, 1); end
        checks++; if (t_c != 1 + BW) begin errors++; $display("FAIL cp_rise got %0d exp %0d", t_c, 1 + BW); end
        checks++; if (t_v != 1 + BW + CW) begin errors++; $display("FAIL vco_rise got %0d exp %0d", t_v, 1 + BW + CW); end
        checks++; if (t_r != 1 + BW + CW + LW) begin errors++; $display("FAIL ready_rise got %0d exp %0d", t_r, 1 + BW + CW + LW); end
        checks++; if (t_s != 2 + BW + CW + LW) begin errors++; $display("FAIL clksel_rise got %0d exp %0d", t_s, 2 + BW + CW + LW); end
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        tick();
        checks++;
        if ({pll_ready, clk_sel} !== 2'b10) begin
            errors++; $display("FAIL bypass_on got %b exp 10", {pll_ready, clk_sel});
        end
        tick();
        bypass = 1'b0;
        tick();
        checks++;
        if ({pll_ready, clk_sel} !== 2'b11) begin
            errors++; $display("FAIL bypass_off got %b exp 11", {pll_ready, clk_sel});
        end
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL bypass_model got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_trim_relock();
        int lo_r, lo_s;
        bit drop;
        lo_r = 0; lo_s = 0; drop = 0;
        trim_we = 1'b1; trim_wdata = 4'hA;
        tick();
        trim_we = 1'b0;
        checks++;
        if (B !== 4'hA) begin errors++; $display("FAIL trim_B got %h exp a", B); end
        for (int n = 0; n < 700; n++) begin
            if (n > 0) begin
                tick();
                checks++;
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL relock_cycle %0d got %h exp %h", n, dut_vec(), model_vec());
                end
            end
            if (!(bias_en && EN_CP && EN_VCO)) drop = 1;
            if (!pll_ready) lo_r++;
            if (!clk_sel) lo_s++;
            if (clk_sel) break;
        end
        checks++; if (lo_r != LW) begin errors++; $display("FAIL relock_ready_low got %0d exp %0d", lo_r, LW); end
        checks++; if (lo_s != LW + 1) begin errors++; $display("FAIL relock_sel_low got %0d exp %0d", lo_s, LW + 1); end
        checks++; if (drop) begin errors++; $display("FAIL relock_enables got dropped exp held"); end
    endtask

    task automatic test_shutdown();
        logic [3:0] exp_sd [4];
        exp_sd = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({pll_ready, EN_VCO, EN_CP, bias_en} !== exp_sd[k]) begin
                errors++;
                $display("FAIL shutdown_step %0d got %b exp %b", k + 1, {pll_ready, EN_VCO, EN_CP, bias_en}, exp_sd[k]);
            end
        end
        checks++;
        if (state !== 3'd0 || clk_sel !== 1'b0) begin
            errors++; $display("FAIL shutdown_off got state %0d sel %b exp 0 0", state, clk_sel);
        end
    endtask

    task automatic test_async_reset();
        int cnt;
        cnt = 0;
        enable = 1'b1;
        for (int n = 0; n < 200; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL locking_cycle %0d got %h exp %h", n, dut_vec(), model_vec());
            end
            trim_we = 1'b0;
            if (state == 3'd3) cnt++;
            if (cnt == 5) begin trim_we = 1'b1; trim_wdata = 4'h3; end
            if (cnt == 20) break;
        end
        #2;
        RESET = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            errors++; $display("FAIL async_reset got %h exp %h", dut_vec(), RST_VEC);
        end
        model_reset();
        enable = 1'b0;
        tick();
        RESET = 1'b0;
        checks++;
        if (dut_vec() !== model_vec()) begin
            errors++; $display("FAIL reset_hold got %h exp %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_cp_toggle();
        int cp_seen, bias_cnt;
        bit saw_off, done;
        logic [7:0] seen;
        cp_seen = 0; bias_cnt = 0; saw_off = 0; done = 0; seen = '0;
        enable = 1'b1;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (state == 3'd2) cp_seen++;
            if (cp_seen == 3) break;
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        seen[state] = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL toggle_cycle %0d got %h exp %h", n, dut_vec(), model_vec());
            end
            seen[state] = 1'b1;
            if (state == 3'd0) saw_off = 1;
            if (saw_off && state == 3'd1) bias_cnt++;
            if (saw_off && EN_CP) done = 1;
        end
        checks++;
        if (seen[7:5] !== 3'b111 || !saw_off) begin
            errors++; $display("FAIL toggle_stop_seq got %b exp 111 with off", seen[7:5]);
        end
        checks++;
        if (bias_cnt != BW) begin errors++; $display("FAIL toggle_bias_wait got %0d exp %0d", bias_cnt, BW); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 5000; n++) begin
            if (enable) enable = ($urandom_range(0, 799) != 0);
            else        enable = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) bypass = ~bypass;
            trim_we = ($urandom_range(0, 299) == 0);
            trim_wdata = 4'($urandom);
            tick();
            checks++;
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random_cycle %0d got %h exp %h", n, dut_vec(), model_vec());
            end
        end
        trim_we = 1'b0;
        bypass = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_powerup();
        test_bypass();
        test_trim_relock();
        test_shutdown();
        test_async_reset();
        test_cp_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
